// File: rtl/eth_fcs_check_if.sv
// Byte-wide AXI-stream bundle used on both sides of the RX FCS checker.
interface eth_fcs_check_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_fcs_check.sv
// Receive-side Ethernet FCS checker: CRC-32 over every byte including the FCS,
// optional FCS stripping via a 4-byte delay buffer, bad frames flagged in tuser.
module eth_fcs_check #(
  parameter bit FCS_STRIP = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  eth_fcs_check_if.slave         s_axis,
  eth_fcs_check_if.master        m_axis,
  output logic                   error_bad_fcs,
  output logic                   error_runt
);

  localparam logic [31:0] CrcInit    = 32'hFFFF_FFFF;
  localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;

  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  logic [31:0] crc_q, crc_d, crc_calc;
  logic [31:0] buf_q, buf_d;   // oldest byte in [31:24], newest in [7:0]
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic        bad_fcs_q, bad_fcs_d;
  logic        runt_q, runt_d;
  logic        s_ready, accept, fcs_bad;

  assign s_ready       = m_axis.tready || !tvalid_q;
  assign s_axis.tready = s_ready;
  assign accept        = s_axis.tvalid && s_ready;

  always_comb begin
    crc_calc  = crc_next(crc_q, s_axis.tdata);
    fcs_bad   = (crc_calc != CrcResidue);
    crc_d     = crc_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tuser_d   = tuser_q;
    bad_fcs_d = 1'b0;
    runt_d    = 1'b0;

    if (m_axis.tready) tvalid_d = 1'b0;

    if (accept) begin
      crc_d = s_axis.tlast ? CrcInit : crc_calc;
      if (FCS_STRIP) begin
        if (!s_axis.tlast) begin
          buf_d = {buf_q[23:0], s_axis.tdata};
          if (cnt_q == 3'd4) begin
            tdata_d  = buf_q[31:24];
            tvalid_d = 1'b1;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          // Remaining buffered bytes are the FCS and are dropped.
          buf_d = '0;
          cnt_d = '0;
          if (cnt_q == 3'd4) begin
            tdata_d   = buf_q[31:24];
            tvalid_d  = 1'b1;
            tlast_d   = 1'b1;
            tuser_d   = s_axis.tuser | fcs_bad;
            bad_fcs_d = fcs_bad;
          end else begin
            runt_d = 1'b1;
          end
        end
      end else begin
        tdata_d   = s_axis.tdata;
        tvalid_d  = 1'b1;
        tlast_d   = s_axis.tlast;
        tuser_d   = s_axis.tlast & (s_axis.tuser | fcs_bad);
        bad_fcs_d = s_axis.tlast & fcs_bad;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q     <= CrcInit;
      buf_q     <= '0;
      cnt_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= 1'b0;
      bad_fcs_q <= 1'b0;
      runt_q    <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
      bad_fcs_q <= bad_fcs_d;
      runt_q    <= runt_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;
  assign error_bad_fcs = bad_fcs_q;
  assign error_runt    = runt_q;

endmodule

// File: doc/eth_fcs_check.md
Name: eth_fcs_check

Overview:
- Receive-side Ethernet FCS checker for the 8-bit AXI-stream MAC datapath. It is the counterpart of the transmit-side CRC-32 generator.
- Runs the standard Ethernet CRC-32 over every received byte, including the 4 trailing FCS bytes.
- Strips the FCS (parameter controlled) and marks frames with a bad FCS through tuser on the last output beat.
- Sits between the GMII/RGMII RX framer (preamble/SFD already removed) and the RX FIFO.

Parameters:
- FCS_STRIP, 1, 1: remove the 4 FCS bytes from the output stream; 0: pass all bytes through, check only.

Ports:
- clk  input  1  Single clock for the whole block.
- rst  input  1  Asynchronous, active-high reset.
- s_axis_tdata  input  8  Received byte.
- s_axis_tvalid  input  1  Input beat valid.
- s_axis_tready  output  1  Block accepts input beat.
- s_axis_tlast  input  1  Last byte of frame; this is the final FCS byte.
- s_axis_tuser  input  1  Upstream error flag; sampled only on the tlast beat.
- m_axis_tdata  output  8  Output byte.
- m_axis_tvalid  output  1  Output beat valid.
- m_axis_tready  input  1  Downstream accepts output beat.
- m_axis_tlast  output  1  Last output byte of frame.
- m_axis_tuser  output  1  Frame bad; meaningful on tlast only.
- error_bad_fcs  output  1  One-cycle pulse: frame finished with CRC mismatch.
- error_runt  output  1  One-cycle pulse: frame of 4 bytes or fewer was dropped (FCS_STRIP=1 only).

Behaviour:
- **Reset.** On rst, all of the following clear to 0 immediately (asynchronous): m_axis_tvalid, tlast, tuser, tdata, error_bad_fcs, error_runt, the buffer byte count and the buffer contents. The CRC state is set to 32'hFFFFFFFF.
- **Input handshake.** A beat is accepted when s_axis_tvalid && s_axis_tready. s_axis_tready = m_axis_tready || !m_axis_tvalid. The output is a single register stage.
- **CRC calculation.**
  - Reflected CRC-32, polynomial 0x04C11DB7, bytes processed LSB first, one byte per accepted beat.
  - On every accepted beat: crc <= crc_next(crc, tdata).
  - On an accepted tlast beat: the frame is good iff crc_next == 32'hDEBB20E3, then crc <= 32'hFFFFFFFF.
- **Buffer when FCS_STRIP=1.**
  - A 4-entry byte shift buffer holds bytes, with a count from 0 to 4.
  - Accepted non-last beat with count<4: shift the byte in, count+1, no output.
  - Accepted non-last beat with count==4: shift the byte in, load the oldest byte into m_axis (tvalid=1, tlast=0).
  - Accepted tlast beat with count==4: load the oldest byte with tlast=1 and tuser = s_axis_tuser | bad. Discard the remaining buffer, since it is the FCS. Set count to 0.
  - Accepted tlast beat with count<4 (frame of 4 bytes or fewer): emit nothing, pulse error_runt, set count to 0, reset the CRC, and do not pulse error_bad_fcs.
- **FCS_STRIP=0.** Every accepted beat is registered straight to the output with latency 1. On the tlast beat, tuser = s_axis_tuser | bad. The buffer is unused and error_runt stays 0.
- **Output handshake.** m_axis_tvalid clears when m_axis_tready && !(a new beat loads in the same cycle). Data stays stable while tvalid && !tready.
- **Error pulses.**
  - error_bad_fcs is high for exactly one cycle, the cycle after a bad tlast beat is accepted.
  - An upstream tuser=1 alone does not pulse error_bad_fcs.
- **Back-to-back frames.** The first byte of the next frame may be accepted in the cycle right after tlast. The CRC reinit and count clear take effect for that byte.
- **Reset mid-frame.** The partial frame is lost and no tlast is emitted. The next accepted byte is treated as the start of a frame.
- **Throughput.** One byte per cycle with m_axis_tready held at 1.

Test Plan:
- **Good frame, FCS_STRIP=1.** Send ASCII "123456789" (0x31..0x39) followed by 0x26 0x39 0xF4 0xCB, tlast on 0xCB, with m_axis_tready=1. Required: exactly 9 output beats 0x31..0x39, tlast on 0x39, tuser=0, error_bad_fcs never asserts.
- **Corrupt FCS.** Same frame with the last byte 0xCA. Required: 9 output beats, tuser=1 on 0x39, error_bad_fcs high for exactly 1 cycle.
- **Runt and upstream error.**
  - Send 4 bytes 0x01 0x02 0x03 0x04 with tlast. Required: no m_axis_tvalid, error_runt pulses once.
  - Then send the good 13-byte frame with s_axis_tuser=1 on tlast. Required: tuser=1 on the output, error_bad_fcs=0.
- **Backpressure and back-to-back.**
  - Drive m_axis_tready with the pattern 1,0,0,1,0 repeating, on two back-to-back good frames with no idle cycle between them.
  - Required: both frames come out byte-exact, with tlast on 0x39 each time and tuser=0 for both, which proves the CRC reinitialises. No beat is duplicated or lost.
- **FCS_STRIP=0.** Send the good 13-byte frame. Required: 13 output beats, 1-cycle latency, tlast on 0xCB, tuser=0.
- **Reset mid-frame.** Assert rst asynchronously (off the clock edge) after byte 6. Required: all outputs read 0 immediately. The following good frame is then output correctly with tuser=0.
